uart_tx_cfg: RTL and testbench

//  Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_tick.sv | 45 ++++
 rtl/uart_tx_cfg.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   - FSM state encoding (S_IDLE..S_STOP)
//   - minimum supported data length (DATA_MIN)
//   - parity mode constants (PAR_EVEN / PAR_ODD)
//   - clamp_data_bits(): maps an out-of-range data length request to the maximum
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned DATA_MIN = 5;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_REQ    = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD   = 3'd2;
    localparam logic [STATE_W-1:0] S_START  = 3'd3;
    localparam logic [STATE_W-1:0] S_DATA   = 3'd4;
    localparam logic [STATE_W-1:0] S_PARITY = 3'd5;
    localparam logic [STATE_W-1:0] S_STOP   = 3'd6;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    // Requests outside DATA_MIN..max_bits fall back to max_bits.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0]  req,
                                                   input int unsigned max_bits);
        if ((32'(req) < DATA_MIN) || (32'(req) > max_bits)) begin
            return 4'(max_bits);
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Loadable down-counter that times one serial bit.
//   i_clk, i_rst_n     clock / async active-low reset
//   i_load             load i_load_val (start of a new bit)
//   i_load_val         clocks per bit (>= 1)
//   o_bit_tick_c       high on the last clock of the current bit
//   o_pre_tick_c       high on the second-to-last clock of the current bit
// The counter parks at 1 (no wrap); the owner reloads it for every bit.
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned P_DIV_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [P_DIV_W-1:0] i_load_val,
    output logic               o_bit_tick_c,
    output logic               o_pre_tick_c
);

    logic [P_DIV_W-1:0] cnt_q, cnt_d;

    // Next count: load, else count down and hold at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q > P_DIV_W'(1)) begin
            cnt_d = cnt_q - P_DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_tick_c = (cnt_q == P_DIV_W'(1));
    assign o_pre_tick_c = (cnt_q == P_DIV_W'(2));

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter. Pops one byte at a time from a TX FIFO
// (data valid the cycle after the pop strobe) and serialises it LSB-first as
// start / data / optional parity / 1-2 stop bits on o_sig.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit; without it the
// parity ports are accepted but ignored).
// Ports:
//   i_clk, i_rst_n     clock / async active-low reset
//   i_div              clocks per bit (0 behaves as 1)
//   i_data_bits        data bits per frame, 5..P_DATA_MAX (else P_DATA_MAX)
//   i_stop2            two stop bits when set
//   i_parity_en        parity enable
//   i_parity_odd       odd parity when set, even otherwise
//   i_fifo_rd_data     FIFO read data
//   i_fifo_empty       FIFO empty flag
//   o_fifo_rd_en       one-cycle pop strobe
//   o_sig              serial line, idle high
//   o_busy             high from pop strobe to end of the last stop bit
//   o_done             pulse on the final clock of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned P_DATA_MAX = 8,
    parameter int unsigned P_DIV_W    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [P_DIV_W-1:0]    i_div,
    input  logic [3:0]            i_data_bits,
    input  logic                  i_stop2,
    input  logic                  i_parity_en,
    input  logic                  i_parity_odd,
    input  logic [P_DATA_MAX-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    output logic                  o_sig,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned BIT_CNT_W = $clog2(P_DATA_MAX + 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [P_DATA_MAX-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]            len_q, len_d;
    logic [P_DIV_W-1:0]    div_q, div_d;
    logic                  stop_more_q, stop_more_d;
    logic                  sig_q, sig_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  par_bit;
    logic                  baud_load;
    logic                  bit_tick;
    logic                  pre_tick;
    logic                  tick_next;

`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    par_mode_e             par_mode_q, par_mode_d;
`else
    logic                  unused_parity;
    assign unused_parity = i_parity_en ^ i_parity_odd;
`endif

    uart_baud_tick #(
        .P_DIV_W (P_DIV_W)
    ) u_baud (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (baud_load),
        .i_load_val   (div_d),
        .o_bit_tick_c (bit_tick),
        .o_pre_tick_c (pre_tick)
    );

    // Next-state, datapath and registered-output lookahead.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        div_d       = div_q;
        stop_more_d = stop_more_q;
        baud_load   = 1'b0;
        par_bit     = 1'b1;
        sig_d       = 1'b1;
        rd_en_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        tick_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
        par_en_d    = par_en_q;
        par_mode_d  = par_mode_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!i_fifo_empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d     = i_fifo_rd_data;
                div_d       = (i_div == '0) ? P_DIV_W'(1) : i_div;
                len_d       = clamp_data_bits(i_data_bits, P_DATA_MAX);
                stop_more_d = i_stop2;
                bit_cnt_d   = '0;
                baud_load   = 1'b1;
`ifdef UART_TX_PARITY_EN
                par_d       = 1'b0;
                par_en_d    = i_parity_en;
                par_mode_d  = i_parity_odd ? PAR_ODD : PAR_EVEN;
`endif
                state_d     = S_START;
            end
            S_START: begin
                if (bit_tick) begin
                    baud_load = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    baud_load = 1'b1;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
`ifdef UART_TX_PARITY_EN
                    par_d     = par_q ^ shift_q[0];
`endif
                    if (32'(bit_cnt_d) == 32'(len_q)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    baud_load = 1'b1;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (stop_more_q) begin
                        stop_more_d = 1'b0;
                        baud_load   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef UART_TX_PARITY_EN
        par_bit = par_d ^ (par_mode_d == PAR_ODD);
`endif

        // Line level for the coming cycle follows the coming state.
        case (state_d)
            S_START:  sig_d = 1'b0;
            S_DATA:   sig_d = shift_d[0];
            S_PARITY: sig_d = par_bit;
            default:  sig_d = 1'b1;
        endcase

        // Is the coming cycle the last clock of its bit?
        tick_next = baud_load ? (div_d == P_DIV_W'(1)) : (bit_tick || pre_tick);

        rd_en_d = (state_d == S_REQ);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && !stop_more_d && tick_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            div_q       <= '0;
            stop_more_q <= 1'b0;
            sig_q       <= 1'b1;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
            par_en_q    <= 1'b0;
            par_mode_q  <= PAR_EVEN;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            div_q       <= div_d;
            stop_more_q <= stop_more_d;
            sig_q       <= sig_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
            par_en_q    <= par_en_d;
            par_mode_q  <= par_mode_d;
`endif
        end
    end

    assign o_sig        = sig_q;
    assign o_fifo_rd_en = rd_en_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Self-checking bench for uart_tx_cfg. A small array FIFO feeds the DUT; each
// frame's expected line waveform is built from the frame rules (start, data
// LSB-first, optional parity, stop bits, each div clocks) and compared cycle by
// cycle. Parity cases follow UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`define CHK(TAG, WHAT, OBS, EXP) \
    begin \
        tests++; \
        assert ((OBS) === (EXP)) else begin \
            failures++; \
            $error("FAIL %s/%s: observed %0d expected %0d", TAG, WHAT, OBS, EXP); \
        end \
    end

module tb_uart_tx_cfg;

    localparam int unsigned DMAX = 8;
    localparam int unsigned DIVW = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DIVW-1:0] i_div = 16'd4;
    logic [3:0]      i_data_bits = 4'd8;
    logic            i_stop2 = 1'b0;
    logic            i_parity_en = 1'b0;
    logic            i_parity_odd = 1'b0;
    logic [DMAX-1:0] rd_data = '0;
    logic            fifo_empty;
    logic            o_fifo_rd_en;
    logic            o_sig;
    logic            o_busy;
    logic            o_done;

    int tests = 0;
    int failures = 0;

    logic [7:0] mem [0:31];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;
    int pops = 0;
    int bad_pops = 0;

    int gap_run = 0;
    int last_gap = -1;
    bit gap_armed = 1'b0;

    uart_tx_cfg #(
        .P_DATA_MAX (DMAX),
        .P_DIV_W    (DIVW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_div          (i_div),
        .i_data_bits    (i_data_bits),
        .i_stop2        (i_stop2),
        .i_parity_en    (i_parity_en),
        .i_parity_odd   (i_parity_odd),
        .i_fifo_rd_data (rd_data),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .o_sig          (o_sig),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the pop strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (o_fifo_rd_en) begin
            if (wr_ptr == rd_ptr) begin
                bad_pops++;
            end else begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 5'd1;
            end
            pops++;
        end
    end

    // High-level run between one frame's done pulse and the next start bit.
    always @(negedge clk) begin
        if (o_done) begin
            gap_armed = 1'b1;
            gap_run   = 0;
        end else if (gap_armed) begin
            if (o_sig) begin
                gap_run++;
            end else begin
                last_gap  = gap_run;
                gap_armed = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic set_cfg(input int div, input int nb, input bit s2, input bit pe, input bit po);
        i_div        = DIVW'(div);
        i_data_bits  = 4'(nb);
        i_stop2      = s2;
        i_parity_en  = pe;
        i_parity_odd = po;
    endtask

    // Wait for the pop, then compare the whole frame against the model.
    task automatic check_frame(input logic [7:0] data, input int nb_cfg, input bit s2,
                               input bit pe, input bit po, input int div_cfg,
                               input int new_div, input string tag);
        int  n, d, waited, sig_err, first_err, done_cnt, done_pos, busy_err;
        bit  p;
        logic exp_q[$];
        n = (nb_cfg < 5 || nb_cfg > 8) ? 8 : nb_cfg;
        d = (div_cfg == 0) ? 1 : div_cfg;

        exp_q = {};
        repeat (d) exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (d) exp_q.push_back(data[i]);
            p = p ^ data[i];
        end
        if (PAR_BUILT && pe) begin
            repeat (d) exp_q.push_back(p ^ po);
        end
        repeat (d * (s2 ? 2 : 1)) exp_q.push_back(1'b1);

        waited = 0;
        @(negedge clk);
        while (o_fifo_rd_en !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        `CHK(tag, "pop", o_fifo_rd_en, 1'b1)
        if (o_fifo_rd_en !== 1'b1) return;
        `CHK(tag, "busy_at_pop", o_busy, 1'b1)

        @(negedge clk);
        `CHK(tag, "pop_one_cycle", o_fifo_rd_en, 1'b0)
        `CHK(tag, "load_idle_line", o_sig, 1'b1)

        sig_err = 0; first_err = -1; done_cnt = 0; done_pos = -1; busy_err = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 5 && new_div >= 0) i_div = DIVW'(new_div);
            if (o_sig !== exp_q[i]) begin
                sig_err++;
                if (first_err < 0) first_err = i;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_pos = i;
            end
            if (o_busy !== 1'b1) busy_err++;
        end
        `CHK(tag, "line_mismatch_cycles", sig_err, 0)
        if (sig_err != 0) $display("  %s first bad cycle %0d", tag, first_err);
        `CHK(tag, "done_count", done_cnt, 1)
        `CHK(tag, "done_position", done_pos, exp_q.size() - 1)
        `CHK(tag, "busy_drops", busy_err, 0)

        @(negedge clk);
        `CHK(tag, "post_busy", o_busy, 1'b0)
        `CHK(tag, "post_line", o_sig, 1'b1)
    endtask

    initial begin
        int p0, err;
        logic [7:0] b;
        int nb, dv;
        bit s2, pe, po;

        // Reset state
        repeat (3) @(negedge clk);
        `CHK("reset", "sig", o_sig, 1'b1)
        `CHK("reset", "busy", o_busy, 1'b0)
        `CHK("reset", "done", o_done, 1'b0)
        `CHK("reset", "rd_en", o_fifo_rd_en, 1'b0)
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        `CHK("empty", "no_pop", pops, 0)

        // T2: 8N1 div=4, 0x55
        set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
        push(8'h55);
        check_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 4, -1, "T2_8N1");

        // T3: 7E2 div=3, 0xC1 (bit 7 must not appear)
        set_cfg(3, 7, 1'b1, 1'b1, 1'b0);
        push(8'hC1);
        check_frame(8'hC1, 7, 1'b1, 1'b1, 1'b0, 3, -1, "T3_7E2");

        // T4: 5O1 div=1, 0x1F then 0x00
        set_cfg(1, 5, 1'b0, 1'b1, 1'b1);
        push(8'h1F);
        check_frame(8'h1F, 5, 1'b0, 1'b1, 1'b1, 1, -1, "T4_5O1_1F");
        push(8'h00);
        check_frame(8'h00, 5, 1'b0, 1'b1, 1'b1, 1, -1, "T4_5O1_00");

        // T5: three queued bytes, div=2
        set_cfg(2, 8, 1'b0, 1'b0, 1'b0);
        p0 = pops;
        push(8'hA5); push(8'h3C); push(8'hF0);
        check_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 2, -1, "T5_f1");
        check_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 2, -1, "T5_f2");
        `CHK("T5", "gap12", last_gap, 3)
        check_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 2, -1, "T5_f3");
        `CHK("T5", "gap23", last_gap, 3)
        repeat (10) @(negedge clk);
        `CHK("T5", "pop_count", pops - p0, 3)
        `CHK("T5", "pop_when_empty", bad_pops, 0)

        // T6: divisor change mid-frame applies to the next frame only; 0 acts as 1
        set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
        push(8'h96);
        check_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 4, 8, "T6_div4");
        push(8'h69);
        check_frame(8'h69, 8, 1'b0, 1'b0, 1'b0, 8, -1, "T6_div8");
        set_cfg(0, 6, 1'b1, 1'b0, 1'b0);
        push(8'h2D);
        check_frame(8'h2D, 6, 1'b1, 1'b0, 1'b0, 0, -1, "T6_div0");

        // Randomised frames, including out-of-range data lengths
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom);
            nb = $urandom_range(0, 15);
            dv = $urandom_range(0, 5);
            s2 = 1'($urandom);
            pe = 1'($urandom);
            po = 1'($urandom);
            set_cfg(dv, nb, s2, pe, po);
            push(b);
            check_frame(b, nb, s2, pe, po, dv, -1, "rand");
        end
        `CHK("rand", "pop_when_empty", bad_pops, 0)

        // T1: reset in the middle of a frame
        set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
        push(8'h00);
        err = 0;
        @(negedge clk);
        while (o_fifo_rd_en !== 1'b1 && err < 40) begin
            @(negedge clk);
            err++;
        end
        `CHK("T1", "pop", o_fifo_rd_en, 1'b1)
        repeat (10) @(negedge clk);
        `CHK("T1", "pre_reset_line", o_sig, 1'b0)
        rst_n = 1'b0;
        #1;
        `CHK("T1", "reset_line", o_sig, 1'b1)
        `CHK("T1", "reset_busy", o_busy, 1'b0)
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = pops;
        err = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_sig !== 1'b1 || o_busy !== 1'b0 || o_fifo_rd_en !== 1'b0) err++;
        end
        `CHK("T1", "idle_after_reset", err, 0)
        `CHK("T1", "no_repop", pops, p0)

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
